synth_param_dpram: RTL

Parametrised on-chip RAM for the synthesizer SoC, the successor to the fixed 4x32 single-port Nios scratch memory. Port A is an Avalon-MM slave for the Nios (byte-enabled read/write, fixed read latency with readdatavalid). Port B is a read-only port for the voice engine. A per-word dirty bitmap lets the voice engine find words the CPU has changed since it last read them.

---
 rtl/synth_mem_pkg.sv | 11 +
 rtl/synth_dirty_prio_enc.sv | 16 +
 rtl/synth_param_dpram.sv | 103 ++++++++++
 3 files changed

// File: rtl/synth_mem_pkg.sv
// synth_mem_pkg: shared configuration constants and helpers for the synth SoC memories
package synth_mem_pkg;
  localparam int RL_ONE = 1;
  localparam int RL_TWO = 2;
  function automatic int lanes(input int dw);
    return dw / 8;
  endfunction
  function automatic bit cfg_ok(input int dw, input int rl);
    return (dw % 8 == 0) && (rl == RL_ONE || rl == RL_TWO);
  endfunction
endpackage

// File: rtl/synth_dirty_prio_enc.sv
// synth_dirty_prio_enc: lowest-set-bit encoder over the dirty bitmap
module synth_dirty_prio_enc #(
  parameter int ADDR_W = 4
) (
  input  logic [2**ADDR_W-1:0] vec,
  output logic [ADDR_W-1:0]    idx,
  output logic                 any
);
  // scanning downward lets the lowest set bit overwrite higher ones
  always_comb begin
    idx = '0;
    for (int i = 2**ADDR_W - 1; i >= 0; i--)
      if (vec[i]) idx = ADDR_W'(i);
  end
  assign any = |vec;
endmodule

// File: rtl/synth_param_dpram.sv
// synth_param_dpram: byte-enabled Avalon port A, read-only port B, per-word dirty tracking
module synth_param_dpram
  import synth_mem_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clken,
  input  logic                reset_req,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic                chipselect,
  input  logic                write,
  input  logic                read,
  input  logic [DATA_W-1:0]   writedata,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  input  logic [ADDR_W-1:0]   b_address,
  input  logic                b_read,
  output logic [DATA_W-1:0]   b_readdata,
  output logic                b_readdatavalid,
  output logic                dirty_any,
  output logic [ADDR_W-1:0]   dirty_idx
);
  localparam int LANES = lanes(DATA_W);
  localparam int DEPTH = 2**ADDR_W;
  if (!cfg_ok(DATA_W, READ_LATENCY)) begin : g_cfg_err
    $error("synth_param_dpram: DATA_W must be a multiple of 8 and READ_LATENCY 1 or 2");
  end
  logic en, we, rd_a, rd_b;
  assign en   = clken & ~reset_req;
  assign we   = en & chipselect & write;
  assign rd_a = en & chipselect & read & ~write;
  assign rd_b = en & b_read;
  logic [DATA_W-1:0] mem [DEPTH];
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    always_ff @(posedge clk)
      if (we && byteenable[l]) mem[address][l*8 +: 8] <= writedata[l*8 +: 8];
  end
  logic [DATA_W-1:0] a_d1, b_d1;
  logic              a_v1, b_v1;
  always_ff @(posedge clk)
    if (reset) begin
      a_v1 <= 1'b0;
      b_v1 <= 1'b0;
      a_d1 <= '0;
      b_d1 <= '0;
    end else if (en) begin
      a_v1 <= rd_a;
      b_v1 <= rd_b;
      if (rd_a) a_d1 <= mem[address];
      if (rd_b) b_d1 <= mem[b_address];
    end
  if (READ_LATENCY == RL_TWO) begin : g_rl2
    logic [DATA_W-1:0] a_d2, b_d2;
    logic              a_v2, b_v2;
    always_ff @(posedge clk)
      if (reset) begin
        a_v2 <= 1'b0;
        b_v2 <= 1'b0;
        a_d2 <= '0;
        b_d2 <= '0;
      end else if (en) begin
        a_v2 <= a_v1;
        b_v2 <= b_v1;
        if (a_v1) a_d2 <= a_d1;
        if (b_v1) b_d2 <= b_d1;
      end
    assign readdata        = a_d2;
    assign readdatavalid   = a_v2;
    assign b_readdata      = b_d2;
    assign b_readdatavalid = b_v2;
  end else begin : g_rl1
    assign readdata        = a_d1;
    assign readdatavalid   = a_v1;
    assign b_readdata      = b_d1;
    assign b_readdatavalid = b_v1;
  end
  logic [DEPTH-1:0]  dirty, set_v, clr_v;
  logic [ADDR_W-1:0] enc_idx;
  logic              enc_any;
  assign set_v = (we && |byteenable) ? DEPTH'(1) << address : '0;
  assign clr_v = rd_b ? DEPTH'(1) << b_address : '0;
  synth_dirty_prio_enc #(.ADDR_W(ADDR_W)) u_enc (
    .vec(dirty),
    .idx(enc_idx),
    .any(enc_any)
  );
  // set is OR-ed after the clear so a same-cycle CPU write keeps the word dirty
  always_ff @(posedge clk)
    if (reset) begin
      dirty     <= '0;
      dirty_any <= 1'b0;
      dirty_idx <= '0;
    end else if (en) begin
      dirty     <= (dirty & ~clr_v) | set_v;
      dirty_any <= enc_any;
      dirty_idx <= enc_idx;
    end
endmodule
